// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants for the 5-stage MIPS pipeline registers: exception codes,
// PC vectors and payload field offsets for the D/E stage packing.
package pipe_stage_reg_pkg;

  localparam int EXC_W_DEF = 5;

  localparam logic [EXC_W_DEF-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_W_DEF-1:0] EXC_INT  = 5'd1;
  localparam logic [EXC_W_DEF-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_W_DEF-1:0] EXC_ADES = 5'd5;
  localparam logic [EXC_W_DEF-1:0] EXC_SYS  = 5'd8;
  localparam logic [EXC_W_DEF-1:0] EXC_RI   = 5'd10;
  localparam logic [EXC_W_DEF-1:0] EXC_OV   = 5'd12;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;

  // D/E payload layout (136 bits)
  localparam int DE_RS_LSB   = 0;
  localparam int DE_RT_LSB   = 32;
  localparam int DE_IMM_LSB  = 64;
  localparam int DE_EXT_LSB  = 96;
  localparam int DE_A3_LSB   = 128;
  localparam int DE_BR_BIT   = 133;
  localparam int DE_MEMW_BIT = 134;
  localparam int DE_REGW_BIT = 135;
  localparam int DE_W        = 136;

endpackage

// File: rtl/pipe_exc_merge.sv
// Exception merge: the older-stage code wins over the local one, and a
// faulting instruction is squashed into a nop (instr and payload zeroed).
module pipe_exc_merge import pipe_stage_reg_pkg::*; #(
  parameter int DATA_W = 136,
  parameter int EXC_W  = EXC_W_DEF
) (
  input  logic [EXC_W-1:0]  in_exc,
  input  logic [EXC_W-1:0]  local_exc,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_data,
  output logic [EXC_W-1:0]  merged_exc,
  output logic [31:0]       merged_instr,
  output logic [DATA_W-1:0] merged_data
);

  always_comb begin
    merged_exc   = (in_exc != '0) ? in_exc : local_exc;
    merged_instr = in_instr;
    merged_data  = in_data;
    if (merged_exc != '0) begin
      merged_instr = '0;
      merged_data  = '0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage register: reset > req > flush > we > hold priority.
// Define PIPE_STAGE_PERF_EN to build the bubble/hold performance counters.
module pipe_stage_reg import pipe_stage_reg_pkg::*; #(
  parameter int          DATA_W     = 136,
  parameter int          EXC_W      = EXC_W_DEF,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              flush,
  input  logic              we,
  input  logic              in_valid,
  input  logic [31:0]       in_instr,
  input  logic [31:0]       in_pc,
  input  logic              in_isbd,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic [EXC_W-1:0]  local_exc,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  output logic              out_isbd,
  output logic [EXC_W-1:0]  out_exc,
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       hold_cnt
);

  logic [EXC_W-1:0]  merged_exc_p0;
  logic [31:0]       merged_instr_p0;
  logic [DATA_W-1:0] merged_data_p0;

  logic              vld_p1;
  logic [31:0]       instr_p1;
  logic [31:0]       pc_p1;
  logic              isbd_p1;
  logic [EXC_W-1:0]  exc_p1;
  logic [DATA_W-1:0] data_p1;

  pipe_exc_merge #(
    .DATA_W (DATA_W),
    .EXC_W  (EXC_W)
  ) u_exc_merge (
    .in_exc       (in_exc),
    .local_exc    (local_exc),
    .in_instr     (in_instr),
    .in_data      (in_data),
    .merged_exc   (merged_exc_p0),
    .merged_instr (merged_instr_p0),
    .merged_data  (merged_data_p0)
  );

  // p0 -> p1 stage boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      instr_p1 <= '0;
      pc_p1    <= RESET_PC;
      isbd_p1  <= 1'b0;
      exc_p1   <= '0;
      data_p1  <= '0;
    end else if (req) begin
      vld_p1   <= 1'b0;
      instr_p1 <= '0;
      pc_p1    <= HANDLER_PC;
      isbd_p1  <= 1'b0;
      exc_p1   <= '0;
      data_p1  <= '0;
    end else if (flush) begin
      // Bubble keeps PC/BD so an EPC taken on it still points at the right slot
      vld_p1   <= 1'b0;
      instr_p1 <= '0;
      pc_p1    <= in_pc;
      isbd_p1  <= in_isbd;
      exc_p1   <= '0;
      data_p1  <= '0;
    end else if (we) begin
      vld_p1   <= in_valid;
      instr_p1 <= merged_instr_p0;
      pc_p1    <= in_pc;
      isbd_p1  <= in_isbd;
      exc_p1   <= merged_exc_p0;
      data_p1  <= merged_data_p0;
    end
  end

  assign out_valid = vld_p1;
  assign out_instr = instr_p1;
  assign out_pc    = pc_p1;
  assign out_isbd  = isbd_p1;
  assign out_exc   = exc_p1;
  assign out_data  = data_p1;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] bubble_q;
  logic [31:0] hold_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_q <= '0;
      hold_q   <= '0;
    end else if (!req) begin
      if (flush)
        bubble_q <= bubble_q + 32'd1;
      else if (!we)
        hold_q <= hold_q + 32'd1;
    end
  end

  assign bubble_cnt = bubble_q;
  assign hold_cnt   = hold_q;
`else
  assign bubble_cnt = '0;
  assign hold_cnt   = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg; counter expectations follow
// PIPE_STAGE_PERF_EN (counters read 0 when the feature is not built).
module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;

  localparam int DATA_W = 136;
  localparam int EXC_W  = 5;

  logic              clk = 1'b0;
  logic              reset, req, flush, we;
  logic              in_valid, in_isbd;
  logic [31:0]       in_instr, in_pc;
  logic [EXC_W-1:0]  in_exc, local_exc;
  logic [DATA_W-1:0] in_data;
  logic              out_valid, out_isbd;
  logic [31:0]       out_instr, out_pc;
  logic [EXC_W-1:0]  out_exc;
  logic [DATA_W-1:0] out_data;
  logic [31:0]       bubble_cnt, hold_cnt;

  int n_total = 0;
  int n_bad   = 0;

  logic [DATA_W-1:0] pat_a5, pat_5a, pat_c3;

  pipe_stage_reg #(
    .DATA_W (DATA_W),
    .EXC_W  (EXC_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .flush      (flush),
    .we         (we),
    .in_valid   (in_valid),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .in_isbd    (in_isbd),
    .in_exc     (in_exc),
    .local_exc  (local_exc),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .out_isbd   (out_isbd),
    .out_exc    (out_exc),
    .out_data   (out_data),
    .bubble_cnt (bubble_cnt),
    .hold_cnt   (hold_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [31:0] ins,
                         input logic [31:0] pc, input logic bd, input logic [EXC_W-1:0] ex,
                         input logic [DATA_W-1:0] d);
    chk({tag, ".valid"}, 256'(out_valid), 256'(v));
    chk({tag, ".instr"}, 256'(out_instr), 256'(ins));
    chk({tag, ".pc"},    256'(out_pc),    256'(pc));
    chk({tag, ".isbd"},  256'(out_isbd),  256'(bd));
    chk({tag, ".exc"},   256'(out_exc),   256'(ex));
    chk({tag, ".data"},  256'(out_data),  256'(d));
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] b, input logic [31:0] h);
`ifdef PIPE_STAGE_PERF_EN
    chk({tag, ".bubble_cnt"}, 256'(bubble_cnt), 256'(b));
    chk({tag, ".hold_cnt"},   256'(hold_cnt),   256'(h));
`else
    chk({tag, ".bubble_cnt"}, 256'(bubble_cnt), 256'(b & 32'd0));
    chk({tag, ".hold_cnt"},   256'(hold_cnt),   256'(h & 32'd0));
`endif
  endtask

  initial begin
    pat_a5 = {17{8'hA5}};
    pat_5a = {17{8'h5A}};
    pat_c3 = {17{8'hC3}};

    // Reset with live load inputs
    reset = 1; req = 0; flush = 0; we = 1;
    in_valid = 1; in_instr = 32'hDEAD_BEEF; in_pc = 32'h3010; in_isbd = 1;
    in_exc = 0; local_exc = 0; in_data = pat_c3;
    step();
    chk_all("reset", 1'b0, 32'h0, 32'h3000, 1'b0, 5'd0, '0);
    chk_cnt("reset", 32'd0, 32'd0);
    reset = 0;

    // Normal load
    in_valid = 1; in_instr = 32'h8C41_0004; in_pc = 32'h3004; in_isbd = 0;
    in_data = pat_a5;
    step();
    chk_all("load", 1'b1, 32'h8C41_0004, 32'h3004, 1'b0, 5'd0, pat_a5);

    // Local exception only -> squashed to nop carrying RI
    in_pc = 32'h300C; local_exc = EXC_RI;
    step();
    chk_all("local_ri", 1'b1, 32'h0, 32'h300C, 1'b0, 5'd10, '0);

    // Older-stage code wins over local
    in_pc = 32'h3010; in_exc = EXC_ADEL; local_exc = EXC_RI;
    step();
    chk_all("older_wins", 1'b1, 32'h0, 32'h3010, 1'b0, 5'd4, '0);

    // Invalid slot still latches its code
    in_valid = 0; in_pc = 32'h3014; in_exc = EXC_ADES; local_exc = 0;
    step();
    chk_all("inv_exc", 1'b0, 32'h0, 32'h3014, 1'b0, 5'd5, '0);

    // Bubble with we=1
    in_valid = 1; in_exc = 0; in_instr = 32'h1234_5678; in_data = pat_5a;
    flush = 1; we = 1; in_pc = 32'h3008; in_isbd = 1;
    step();
    chk_all("bubble", 1'b0, 32'h0, 32'h3008, 1'b1, 5'd0, '0);
    chk_cnt("bubble", 32'd1, 32'd0);

    // Bubble with we=0 still applies
    we = 0; in_pc = 32'h3018; in_isbd = 0;
    step();
    chk_all("bubble_nowe", 1'b0, 32'h0, 32'h3018, 1'b0, 5'd0, '0);
    chk_cnt("bubble_nowe", 32'd2, 32'd0);

    // Exception request overrides flush and we, counters untouched
    req = 1; flush = 1; we = 1; in_isbd = 1; local_exc = EXC_OV;
    step();
    chk_all("req", 1'b0, 32'h0, 32'h4180, 1'b0, 5'd0, '0);
    chk_cnt("req", 32'd2, 32'd0);
    req = 0; flush = 0; local_exc = 0;

    // Load, then hold three cycles with changing inputs
    in_valid = 1; in_instr = 32'h0022_1820; in_pc = 32'h3020; in_isbd = 0; in_data = pat_5a;
    step();
    chk_all("load2", 1'b1, 32'h0022_1820, 32'h3020, 1'b0, 5'd0, pat_5a);
    we = 0;
    for (int i = 0; i < 3; i++) begin
      in_instr = in_instr + 32'h11; in_pc = in_pc + 32'd4; in_data = ~in_data;
      in_valid = i[0]; in_isbd = ~in_isbd; local_exc = 5'(i + 1);
      step();
      chk_all("hold", 1'b1, 32'h0022_1820, 32'h3020, 1'b0, 5'd0, pat_5a);
    end
    chk_cnt("hold", 32'd2, 32'd3);

    // Reset mid-stall wins, next edge holds normally
    reset = 1;
    step();
    chk_all("reset_stall", 1'b0, 32'h0, 32'h3000, 1'b0, 5'd0, '0);
    chk_cnt("reset_stall", 32'd0, 32'd0);
    reset = 0;
    step();
    chk_all("post_reset_hold", 1'b0, 32'h0, 32'h3000, 1'b0, 5'd0, '0);
    chk_cnt("post_reset_hold", 32'd0, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
